// File: rtl/band_level_meter_if.sv
// Level stream handshake between band_level_meter and its consumer.
// Producer drives valid/chan/data; consumer drives ready.
interface band_level_meter_if;
    logic        level_valid;
    logic        level_ready;
    logic [2:0]  level_chan;
    logic [15:0] level_data;

    modport master (
        output level_valid,
        output level_chan,
        output level_data,
        input  level_ready
    );

    modport slave (
        input  level_valid,
        input  level_chan,
        input  level_data,
        output level_ready
    );
endinterface

// File: rtl/band_level_meter.sv
// Eight-band level meter: delayed snapshot, saturated magnitude, streamed out.
// Define PEAK_HOLD_EN for peak-hold with per-frame decay; otherwise level = |snap|.
module band_level_meter #(
    parameter int CAPTURE_DELAY = 72,
    parameter int DECAY_SHIFT   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               din_enable,
    input  logic signed [15:0] bank0,
    input  logic signed [15:0] bank1,
    input  logic signed [15:0] bank2,
    input  logic signed [15:0] bank3,
    input  logic signed [15:0] bank4,
    input  logic signed [15:0] bank5,
    input  logic signed [15:0] bank6,
    input  logic signed [15:0] bank7,
    band_level_meter_if.master lvl,
    output logic               frame_done,
    output logic               overrun
);

    localparam int CW = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CAPTURE_DELAY - 1);

    if (CAPTURE_DELAY < 1 || DECAY_SHIFT < 1 || DECAY_SHIFT > 15) begin : g_bad_cfg
    end

    typedef enum logic [1:0] {IDLE, WAIT, UPDATE, SEND} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [2:0]         idx, idx_nxt;
    logic               valid_q, valid_nxt;
    logic               done_nxt, ovr_nxt;
    logic               snap_en, peak_en, xfer;
    logic signed [15:0] bank [8];
    logic signed [15:0] snap [8];
    logic [14:0]        peak [8];
    logic [14:0]        peak_upd [8];

    function automatic logic [14:0] mag_of(input logic signed [15:0] s);
        logic [15:0] neg;
        neg = 16'(-s);
        if (s == 16'sh8000)
            return 15'h7fff;
        else if (s[15])
            return neg[14:0];
        else
            return s[14:0];
    endfunction

    always_comb begin
        bank[0] = bank0;
        bank[1] = bank1;
        bank[2] = bank2;
        bank[3] = bank3;
        bank[4] = bank4;
        bank[5] = bank5;
        bank[6] = bank6;
        bank[7] = bank7;
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            peak_upd[i] = mag_of(snap[i]);
`ifdef PEAK_HOLD_EN
            begin
                logic [14:0] mag, dec;
                mag = mag_of(snap[i]);
                dec = peak[i] - (peak[i] >> DECAY_SHIFT);
                peak_upd[i] = (mag >= dec) ? mag : dec;
            end
`endif
        end
    end

    assign xfer = valid_q & lvl.level_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        ovr_nxt   = overrun;
        snap_en   = 1'b0;
        peak_en   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = LOAD;
                if (din_enable)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (din_enable)
                    ovr_nxt = 1'b1;
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    snap_en   = 1'b1;
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                if (din_enable)
                    ovr_nxt = 1'b1;
                peak_en   = 1'b1;
                idx_nxt   = 3'd0;
                valid_nxt = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                valid_nxt = 1'b1;
                if (xfer && idx == 3'd7) begin
                    // A strobe on the closing transfer starts the next frame.
                    idx_nxt   = 3'd0;
                    valid_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    if (din_enable) begin
                        state_nxt = WAIT;
                        cnt_nxt   = LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (xfer)
                        idx_nxt = idx + 3'd1;
                    if (din_enable)
                        ovr_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            valid_q    <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            valid_q    <= valid_nxt;
            frame_done <= done_nxt;
            overrun    <= ovr_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                snap[i] <= '0;
                peak[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (snap_en)
                    snap[i] <= bank[i];
                if (peak_en)
                    peak[i] <= peak_upd[i];
            end
        end
    end

    assign lvl.level_valid = valid_q;
    assign lvl.level_chan  = idx;
    assign lvl.level_data  = {1'b0, peak[idx]};

endmodule
